// File: rtl/la_trace_decoder.sv
// Receive-side RLE expander for logic-analyzer trace packets {rc, sig}.
// Rebuilds the per-cycle sample stream and keeps host-visible counters.
//
// state  | meaning
// IDLE   | no packet in flight; s_tready follows dec_enable
// EXPAND | replaying the captured sample until remain reaches its final count
module la_trace_decoder #(
  parameter int pSIG_WIDTH = 24,
  parameter int pRC_WIDTH  = 8,
  parameter int pCNT_WIDTH = 32
) (
  input  logic                            axis_clk,
  input  logic                            axis_rst,
  input  logic                            dec_enable,
  input  logic                            cnt_clr,
  input  logic [pRC_WIDTH+pSIG_WIDTH-1:0] s_tdata,
  input  logic                            s_tvalid,
  input  logic                            s_tlast,
  output logic                            s_tready,
  output logic [pSIG_WIDTH-1:0]           smp_data,
  output logic                            smp_valid,
  output logic                            smp_unknown,
  output logic                            smp_last,
  input  logic                            smp_ready,
  output logic [pCNT_WIDTH-1:0]           sample_count,
  output logic [15:0]                     pkt_count,
  output logic [15:0]                     null_count,
  output logic                            err_zero_rc
);

  typedef enum logic {IDLE = 1'b0, EXPAND = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [pRC_WIDTH-1:0]   remain;
  logic                   last_q;
  logic [pRC_WIDTH-1:0]   rc;
  logic                   is_null;
  logic                   zero_rc;
  logic                   final_smp;
  logic                   smp_hs;
  logic                   accept;

  assign rc        = s_tdata[pRC_WIDTH+pSIG_WIDTH-1 -: pRC_WIDTH];
  assign is_null   = (s_tdata == '0);
  assign zero_rc   = (rc == '0);
  assign final_smp = (remain == pRC_WIDTH'(1));
  assign smp_valid = (state == EXPAND);
  assign smp_hs    = smp_valid & smp_ready;

  // Ready bypasses from smp_ready so the next packet loads on the final handshake.
  assign s_tready  = dec_enable & ~axis_rst & ((state == IDLE) | (smp_hs & final_smp));
  assign accept    = s_tvalid & s_tready;
  assign smp_last  = last_q & final_smp;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXPAND;
      EXPAND:  if (smp_hs && final_smp && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Null and zero-rc packets both expand to exactly one sample.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      remain      <= '0;
      smp_data    <= '0;
      smp_unknown <= 1'b0;
      last_q      <= 1'b0;
    end else if (accept) begin
      remain      <= zero_rc ? pRC_WIDTH'(1) : rc;
      smp_data    <= s_tdata[pSIG_WIDTH-1:0];
      smp_unknown <= is_null;
      last_q      <= s_tlast;
    end else if (smp_hs) begin
      remain      <= remain - pRC_WIDTH'(1);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst || cnt_clr) begin
      sample_count <= '0;
      pkt_count    <= '0;
      null_count   <= '0;
      err_zero_rc  <= 1'b0;
    end else begin
      if (smp_hs && !(&sample_count))
        sample_count <= sample_count + pCNT_WIDTH'(1);
      if (accept && !is_null)
        pkt_count <= pkt_count + 16'd1;
      if (accept && is_null && !(&null_count))
        null_count <= null_count + 16'd1;
      if (accept && !is_null && zero_rc)
        err_zero_rc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_la_trace_decoder.sv
// Bench for la_trace_decoder: queue-based expected-sample model checked every
// cycle, directed packets with literal expectations, then randomized traffic.
module tb_la_trace_decoder;

  logic        axis_clk = 1'b0;
  logic        axis_rst;
  logic        dec_enable;
  logic        cnt_clr;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [23:0] smp_data;
  logic        smp_valid;
  logic        smp_unknown;
  logic        smp_last;
  logic        smp_ready;
  logic [31:0] sample_count;
  logic [15:0] pkt_count;
  logic [15:0] null_count;
  logic        err_zero_rc;

  la_trace_decoder dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .dec_enable(dec_enable), .cnt_clr(cnt_clr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_unknown(smp_unknown),
    .smp_last(smp_last), .smp_ready(smp_ready), .sample_count(sample_count),
    .pkt_count(pkt_count), .null_count(null_count), .err_zero_rc(err_zero_rc)
  );

  always #5 axis_clk = ~axis_clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: queue of samples still owed downstream, plus host counters.
  typedef struct { logic [23:0] d; bit u; bit l; } smp_t;
  smp_t        q[$];
  logic [31:0] m_samples = 0;
  logic [15:0] m_pkts    = 0;
  logic [15:0] m_nulls   = 0;
  bit          m_err     = 0;

  function automatic bit exp_ready();
    return dec_enable && !axis_rst && (q.size() == 0 || (q.size() == 1 && smp_ready));
  endfunction

  always @(posedge axis_clk) begin
    bit acc, hs, nul;
    int n;
    if (axis_rst) begin
      q.delete();
      m_samples = 0; m_pkts = 0; m_nulls = 0; m_err = 0;
    end else begin
      hs  = (q.size() > 0) && smp_ready;
      acc = s_tvalid && exp_ready();
      nul = (s_tdata == 32'h0);
      if (hs) void'(q.pop_front());
      if (acc) begin
        n = (s_tdata[31:24] == 8'h0) ? 1 : int'(s_tdata[31:24]);
        for (int i = 0; i < n; i++)
          q.push_back('{s_tdata[23:0], nul, s_tlast && (i == n - 1)});
      end
      if (cnt_clr) begin
        m_samples = 0; m_pkts = 0; m_nulls = 0; m_err = 0;
      end else begin
        if (hs && m_samples != 32'hFFFF_FFFF) m_samples = m_samples + 1;
        if (acc && !nul) m_pkts = m_pkts + 1;
        if (acc && nul && m_nulls != 16'hFFFF) m_nulls = m_nulls + 1;
        if (acc && !nul && s_tdata[31:24] == 8'h0) m_err = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge axis_clk);
      if (chk_en) begin
        bit ev;
        ev = (q.size() > 0);
        check("smp_valid", smp_valid, ev);
        check("s_tready", s_tready, exp_ready());
        check("smp_last", smp_last, ev ? q[0].l : 1'b0);
        if (ev) begin
          check("smp_data", smp_data, q[0].d);
          check("smp_unknown", smp_unknown, q[0].u);
        end
        check("sample_count", sample_count, m_samples);
        check("pkt_count", pkt_count, m_pkts);
        check("null_count", null_count, m_nulls);
        check("err_zero_rc", err_zero_rc, m_err);
      end
    end
  end

  initial begin
    smp_ready = 1'b1;
    forever begin
      @(posedge axis_clk);
      #1;
      case (rdy_mode)
        0:       smp_ready = 1'b1;
        1:       smp_ready = ~smp_ready;
        default: smp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Present a beat and return at edge+1 of the accepting edge; tvalid left high.
  task automatic send_pkt(input logic [31:0] d, input bit last);
    bit acc;
    int n;
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    acc = 0; n = 0;
    while (!acc && n < 3000) begin
      @(negedge axis_clk);
      acc = s_tready;
      @(posedge axis_clk);
      #1;
      n++;
    end
    check("accept_timeout", {31'h0, acc}, 32'h1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 5000) begin
      @(posedge axis_clk);
      #1;
      n++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic clr_pulse();
    cnt_clr = 1'b1;
    @(posedge axis_clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int k;
    axis_rst = 1'b1; dec_enable = 1'b1; cnt_clr = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    chk_en = 1;
    @(negedge axis_clk);
    check("rst_valid", smp_valid, 0);
    check("rst_tready", s_tready, 0);
    check("rst_scount", sample_count, 0);
    @(posedge axis_clk);
    #1;
    axis_rst = 1'b0;
    @(posedge axis_clk);
    #1;

    // Single packet, one-cycle latency
    send_pkt(32'h03ABCDEF, 0);
    s_tvalid = 1'b0;
    @(negedge axis_clk);
    check("t1_first_valid", smp_valid, 1);
    check("t1_first_data", smp_data, 24'hABCDEF);
    drain();
    check("t1_scount", sample_count, 3);
    check("t1_pcount", pkt_count, 1);

    // Null packet with tlast
    clr_pulse();
    send_pkt(32'h0, 1);
    s_tvalid = 1'b0;
    @(negedge axis_clk);
    check("t2_unknown", smp_unknown, 1);
    check("t2_data", smp_data, 0);
    check("t2_last", smp_last, 1);
    drain();
    check("t2_ncount", null_count, 1);
    check("t2_pcount", pkt_count, 0);

    // Back-to-back chaining
    clr_pulse();
    send_pkt(32'h02000001, 0);
    s_tdata = 32'h01000002;
    @(negedge axis_clk);
    check("t3_s0", smp_data, 1);
    check("t3_rdy0", s_tready, 0);
    @(posedge axis_clk);
    #1;
    @(negedge axis_clk);
    check("t3_s1", smp_data, 1);
    check("t3_rdy1", s_tready, 1);
    @(posedge axis_clk);
    #1;
    s_tvalid = 1'b0;
    @(negedge axis_clk);
    check("t3_s2", smp_data, 2);
    check("t3_s2_valid", smp_valid, 1);
    drain();
    check("t3_scount", sample_count, 3);

    // Long packet under toggling backpressure
    clr_pulse();
    rdy_mode = 1;
    send_pkt(32'hFF123456, 0);
    s_tvalid = 1'b0;
    drain();
    check("t4_scount", sample_count, 255);
    rdy_mode = 0;
    @(posedge axis_clk);
    #1;

    // Zero repeat count
    clr_pulse();
    send_pkt(32'h00000005, 0);
    s_tvalid = 1'b0;
    @(negedge axis_clk);
    check("t5_data", smp_data, 24'h000005);
    drain();
    check("t5_err", err_zero_rc, 1);
    check("t5_scount", sample_count, 1);
    clr_pulse();
    @(negedge axis_clk);
    check("t5_clr_err", err_zero_rc, 0);
    check("t5_clr_scount", sample_count, 0);
    check("t5_clr_pcount", pkt_count, 0);
    @(posedge axis_clk);
    #1;

    // Reset mid-expansion
    send_pkt(32'h10AAAAAA, 0);
    s_tvalid = 1'b0;
    k = 0;
    while (m_samples < 4 && k < 100) begin
      @(posedge axis_clk);
      #1;
      k++;
    end
    axis_rst = 1'b1;
    @(posedge axis_clk);
    #1;
    axis_rst = 1'b0;
    @(negedge axis_clk);
    check("t6_valid", smp_valid, 0);
    check("t6_scount", sample_count, 0);
    check("t6_pcount", pkt_count, 0);
    @(posedge axis_clk);
    #1;
    send_pkt(32'h01BBBBBB, 0);
    s_tvalid = 1'b0;
    @(negedge axis_clk);
    check("t6_after_data", smp_data, 24'hBBBBBB);
    drain();
    check("t6_after_scount", sample_count, 1);

    // Randomized traffic
    rdy_mode = 2;
    for (int p = 0; p < 300; p++) begin
      case ($urandom_range(0, 9))
        0:       d = 32'h0;
        1:       d = {8'h00, 24'($urandom_range(1, 24'hFFFFFF))};
        2:       d = {8'($urandom_range(9, 40)), 24'($urandom)};
        default: d = {8'($urandom_range(1, 6)), 24'($urandom)};
      endcase
      if ($urandom_range(0, 9) == 0) begin
        dec_enable = 1'b0;
        s_tdata = d; s_tvalid = 1'b1;
        repeat ($urandom_range(1, 8)) begin
          @(posedge axis_clk);
          #1;
        end
        dec_enable = 1'b1;
      end
      send_pkt(d, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge axis_clk);
          #1;
        end
      end
      if ($urandom_range(0, 24) == 0) clr_pulse();
    end
    s_tvalid = 1'b0;
    drain();
    repeat (3) @(posedge axis_clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
